// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised byte-writable RAM.
// Holds the clear-engine state enum, clog2 and the byte-merge helper.
package ram_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  // byte_merge works on the widest supported word; callers extend/truncate
  localparam int MAX_WSIZE = 16;
  localparam int MAX_DW    = 8 * MAX_WSIZE;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0]    old_w,
    input logic [MAX_DW-1:0]    new_w,
    input logic [MAX_WSIZE-1:0] be
  );
    logic [MAX_DW-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_WSIZE; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_param_if.sv
// Access bus of ram_param: EN0/WE0/A0/Di0 requests, Do0/VLD0/BUSY replies.
// master = requester side, slave = the RAM.
interface ram_param_if #(
  parameter int AW    = 5,
  parameter int WSIZE = 4
);
  logic                 EN0;
  logic [WSIZE-1:0]     WE0;
  logic [AW-1:0]        A0;
  logic [8*WSIZE-1:0]   Di0;
  logic [8*WSIZE-1:0]   Do0;
  logic                 VLD0;
  logic                 BUSY;

  modport master (
    output EN0, WE0, A0, Di0,
    input  Do0, VLD0, BUSY
  );

  modport slave (
    input  EN0, WE0, A0, Di0,
    output Do0, VLD0, BUSY
  );
endinterface

// File: rtl/ram_clear_fsm.sv
// Clear engine: zeroes every word after RST or a CLR0 pulse.
// In: CLK, RST, CLR0. Out: BUSY, clr_we, clr_addr.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int WORDS = 32,
  parameter int AW    = clog2(WORDS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR0,
  output logic          BUSY,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW:0] LAST = (AW+1)'(WORDS - 1);

  clr_state_e  state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (CLR0) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + (AW+1)'(1);
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // RST wins in every state, so a mid-clear reset restarts at word 0
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY     = (state_q == CLEAR);
  assign clr_we   = BUSY;
  assign clr_addr = cnt_q[AW-1:0];

endmodule

// File: rtl/ram_param.sv
// Byte-writable single-port flop RAM with clear engine and read pipeline.
// In: CLK, RST, CLR0, bus (slave). Supports WSIZE up to 16 bytes.
module ram_param
  import ram_pkg::*;
#(
  parameter int WORDS    = 32,
  parameter int WSIZE    = 4,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0,
  localparam int AW      = clog2(WORDS),
  localparam int DW      = 8 * WSIZE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLR0,
  ram_param_if.slave  bus
);

  logic [DW-1:0] mem_q [WORDS];

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  ram_clear_fsm #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_clr (
    .CLK      (CLK),
    .RST      (RST),
    .CLR0     (CLR0),
    .BUSY     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic acc;
  assign acc = bus.EN0 & ~busy;

  logic [DW-1:0]     old_w;
  logic [DW-1:0]     new_w;
  logic [MAX_DW-1:0] merged_full;

  always_comb begin
    old_w       = mem_q[bus.A0];
    merged_full = byte_merge(MAX_DW'(old_w),
                             MAX_DW'(bus.Di0),
                             MAX_WSIZE'(bus.WE0));
    new_w       = merged_full[DW-1:0];
  end

  if (DW < MAX_DW) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^merged_full[MAX_DW-1:DW];
  end

  // clear and access never collide: accesses need !busy
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.A0;
    wr_data = new_w;
    unique case (1'b1)
      clr_we: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        wr_data = '0;
      end
      (acc && |bus.WE0): wr_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  logic [DW-1:0] rd1_q, rd1_d;
  logic          vld1_q, vld1_d;

  always_comb begin
    rd1_d  = '0;
    vld1_d = acc;
    if (acc) rd1_d = (RDW_MODE != 0) ? new_w : old_w;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd1_q  <= '0;
      vld1_q <= 1'b0;
    end else begin
      rd1_q  <= rd1_d;
      vld1_q <= vld1_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] rd2_q, rd2_d;
    logic          vld2_q, vld2_d;

    always_comb begin
      rd2_d  = rd1_q;
      vld2_d = vld1_q;
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        rd2_q  <= '0;
        vld2_q <= 1'b0;
      end else begin
        rd2_q  <= rd2_d;
        vld2_q <= vld2_d;
      end
    end

    assign bus.Do0  = rd2_q;
    assign bus.VLD0 = vld2_q;
  end else begin : g_no_out_reg
    assign bus.Do0  = rd1_q;
    assign bus.VLD0 = vld1_q;
  end

  assign bus.BUSY = busy;

endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: three instances share one stimulus.
// d0: OUT_REG=0/RDW_MODE=0, d1: OUT_REG=0/RDW_MODE=1, d2: OUT_REG=1/RDW_MODE=0.
module tb_ram_param;

  logic clk;
  logic rst;
  logic clr0;
  int   checks;
  int   errors;

  ram_param_if #(.AW(5), .WSIZE(4)) if0 ();
  ram_param_if #(.AW(5), .WSIZE(4)) if1 ();
  ram_param_if #(.AW(5), .WSIZE(4)) if2 ();

  ram_param #(.WORDS(32), .WSIZE(4), .OUT_REG(0), .RDW_MODE(0)) d0 (
    .CLK(clk), .RST(rst), .CLR0(clr0), .bus(if0));
  ram_param #(.WORDS(32), .WSIZE(4), .OUT_REG(0), .RDW_MODE(1)) d1 (
    .CLK(clk), .RST(rst), .CLR0(clr0), .bus(if1));
  ram_param #(.WORDS(32), .WSIZE(4), .OUT_REG(1), .RDW_MODE(0)) d2 (
    .CLK(clk), .RST(rst), .CLR0(clr0), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic en, input logic [3:0] we,
                     input logic [4:0] a, input logic [31:0] di);
    if0.EN0 = en; if0.WE0 = we; if0.A0 = a; if0.Di0 = di;
    if1.EN0 = en; if1.WE0 = we; if1.A0 = a; if1.Di0 = di;
    if2.EN0 = en; if2.WE0 = we; if2.A0 = a; if2.Di0 = di;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (if0.Do0 !== 32'h0 || if0.VLD0 !== 1'b0 || if0.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_d0: do=%h vld=%b busy=%b want 0 0 1",
               if0.Do0, if0.VLD0, if0.BUSY);
    end
    checks++;
    if (if1.Do0 !== 32'h0 || if1.VLD0 !== 1'b0 || if1.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_d1: do=%h vld=%b busy=%b want 0 0 1",
               if1.Do0, if1.VLD0, if1.BUSY);
    end
    checks++;
    if (if2.Do0 !== 32'h0 || if2.VLD0 !== 1'b0 || if2.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_d2: do=%h vld=%b busy=%b want 0 0 1",
               if2.Do0, if2.VLD0, if2.BUSY);
    end
    n = 0;
    while (if0.BUSY === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL reset_busy_len: got %0d cycles want 32", n);
    end
  endtask

  task automatic test_read_cleared();
    for (int a = 0; a < 32; a++) begin
      drv(1'b1, 4'h0, 5'(a), 32'h0);
      tick();
      checks++;
      if (if0.Do0 !== 32'h0 || if0.VLD0 !== 1'b1) begin
        errors++;
        $display("FAIL clr_read_d0[%0d]: do=%h vld=%b want 0 1",
                 a, if0.Do0, if0.VLD0);
      end
      checks++;
      if (if1.Do0 !== 32'h0 || if1.VLD0 !== 1'b1) begin
        errors++;
        $display("FAIL clr_read_d1[%0d]: do=%h vld=%b want 0 1",
                 a, if1.Do0, if1.VLD0);
      end
    end
    drv(1'b0, 4'h0, 5'd0, 32'h0);
    tick();
  endtask

  task automatic test_byte_write();
    drv(1'b1, 4'b1111, 5'd5, 32'hAABBCCDD);
    tick();
    drv(1'b1, 4'b0101, 5'd5, 32'h11223344);
    tick();
    checks++;
    if (if0.Do0 !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL bw_rdw_old_d0: got %h want AABBCCDD", if0.Do0);
    end
    checks++;
    if (if1.Do0 !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL bw_rdw_new_d1: got %h want AA22CC44", if1.Do0);
    end
    drv(1'b1, 4'b0000, 5'd5, 32'h0);
    tick();
    drv(1'b0, 4'b0000, 5'd0, 32'h0);
    checks++;
    if (if0.Do0 !== 32'hAA22CC44 || if0.VLD0 !== 1'b1) begin
      errors++;
      $display("FAIL bw_read_d0: do=%h vld=%b want AA22CC44 1",
               if0.Do0, if0.VLD0);
    end
    tick();
    checks++;
    if (if2.Do0 !== 32'hAA22CC44 || if2.VLD0 !== 1'b1) begin
      errors++;
      $display("FAIL bw_read_d2: do=%h vld=%b want AA22CC44 1",
               if2.Do0, if2.VLD0);
    end
    tick();
  endtask

  task automatic test_rdw();
    drv(1'b1, 4'b1111, 5'd3, 32'h01020304);
    tick();
    drv(1'b1, 4'b0011, 5'd3, 32'hFFFFFFFF);
    tick();
    checks++;
    if (if0.Do0 !== 32'h01020304 || if0.VLD0 !== 1'b1) begin
      errors++;
      $display("FAIL rdw_mode0: do=%h vld=%b want 01020304 1",
               if0.Do0, if0.VLD0);
    end
    checks++;
    if (if1.Do0 !== 32'h0102FFFF || if1.VLD0 !== 1'b1) begin
      errors++;
      $display("FAIL rdw_mode1: do=%h vld=%b want 0102FFFF 1",
               if1.Do0, if1.VLD0);
    end
    drv(1'b1, 4'b0000, 5'd3, 32'h0);
    tick();
    drv(1'b0, 4'b0000, 5'd0, 32'h0);
    checks++;
    if (if0.Do0 !== 32'h0102FFFF) begin
      errors++;
      $display("FAIL rdw_next_d0: got %h want 0102FFFF", if0.Do0);
    end
    checks++;
    if (if1.Do0 !== 32'h0102FFFF) begin
      errors++;
      $display("FAIL rdw_next_d1: got %h want 0102FFFF", if1.Do0);
    end
    tick();
    tick();
  endtask

  task automatic test_disable_pipeline();
    drv(1'b1, 4'b1111, 5'd7, 32'h12345678);
    tick();
    drv(1'b1, 4'b0000, 5'd7, 32'h0);
    tick();
    drv(1'b0, 4'b0000, 5'd0, 32'h0);
    checks++;
    if (if0.Do0 !== 32'h12345678 || if0.VLD0 !== 1'b1) begin
      errors++;
      $display("FAIL pipe_d0_t1: do=%h vld=%b want 12345678 1",
               if0.Do0, if0.VLD0);
    end
    tick();
    checks++;
    if (if2.Do0 !== 32'h12345678 || if2.VLD0 !== 1'b1) begin
      errors++;
      $display("FAIL pipe_d2_t2: do=%h vld=%b want 12345678 1",
               if2.Do0, if2.VLD0);
    end
    checks++;
    if (if0.Do0 !== 32'h0 || if0.VLD0 !== 1'b0) begin
      errors++;
      $display("FAIL dis_d0_t2: do=%h vld=%b want 0 0",
               if0.Do0, if0.VLD0);
    end
    tick();
    checks++;
    if (if2.Do0 !== 32'h0 || if2.VLD0 !== 1'b0) begin
      errors++;
      $display("FAIL dis_d2_t3: do=%h vld=%b want 0 0",
               if2.Do0, if2.VLD0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 4'b1111, 5'(10 + i), 32'hC0DE_0000 + 32'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 4'b0000, 5'(10 + i), 32'h0);
      tick();
      checks++;
      if (if0.Do0 !== 32'hC0DE_0000 + 32'(i) || if0.VLD0 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_read[%0d]: do=%h vld=%b want %h 1",
                 i, if0.Do0, if0.VLD0, 32'hC0DE_0000 + 32'(i));
      end
    end
    drv(1'b0, 4'b0000, 5'd0, 32'h0);
    tick();
  endtask

  task automatic test_clear_access();
    int n;
    int bad;
    drv(1'b1, 4'b1111, 5'd2, 32'h5555AAAA);
    tick();
    drv(1'b0, 4'b0000, 5'd0, 32'h0);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    drv(1'b1, 4'b1111, 5'd2, 32'hDEADBEEF);
    n = 0;
    bad = 0;
    while (if0.BUSY === 1'b1 && n < 100) begin
      if (n > 0 && (if0.Do0 !== 32'h0 || if0.VLD0 !== 1'b0)) bad++;
      if (n > 1 && (if2.Do0 !== 32'h0 || if2.VLD0 !== 1'b0)) bad++;
      n++;
      tick();
    end
    drv(1'b0, 4'b0000, 5'd0, 32'h0);
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL clr0_busy_len: got %0d cycles want 32", n);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_access_out: got %0d nonzero samples want 0", bad);
    end
    drv(1'b1, 4'b0000, 5'd2, 32'h0);
    tick();
    drv(1'b0, 4'b0000, 5'd0, 32'h0);
    checks++;
    if (if0.Do0 !== 32'h0 || if0.VLD0 !== 1'b1) begin
      errors++;
      $display("FAIL clr_a2_read: do=%h vld=%b want 0 1",
               if0.Do0, if0.VLD0);
    end
    tick();
  endtask

  task automatic test_mid_clear_reset();
    int n;
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (if0.BUSY === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL mid_rst_busy_len: got %0d cycles want 32", n);
    end
    checks++;
    if (if2.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_busy_d2: got %b want 0", if2.BUSY);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clr0   = 1'b0;
    drv(1'b0, 4'h0, 5'd0, 32'h0);
    test_reset();
    test_read_cleared();
    test_byte_write();
    test_rdw();
    test_disable_pipeline();
    test_back_to_back();
    test_clear_access();
    test_mid_clear_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
